// File: rtl/room_thermal_model_if.sv
// Climate-loop bus between the controller and the room plant model.
// master = controller side, slave = plant side.
interface room_thermal_model_if;
    logic       heating;
    logic       cooling;
    logic [4:0] ambient;
    logic [4:0] temperature;
    logic       temp_step;
    logic       fault;

    modport master (
        output heating,
        output cooling,
        output ambient,
        input  temperature,
        input  temp_step,
        input  fault
    );

    modport slave (
        input  heating,
        input  cooling,
        input  ambient,
        output temperature,
        output temp_step,
        output fault
    );
endinterface

// File: rtl/room_thermal_model.sv
// Room thermal plant: heat/cool/drift stepping of a 5-bit temperature.
// Optional macro THERMAL_LAG_EN adds a 4-cycle command warm-up delay.
module room_thermal_model #(
    parameter int HEAT_DIV   = 8,
    parameter int COOL_DIV   = 8,
    parameter int DRIFT_DIV  = 32,
    parameter int RESET_TEMP = 18
) (
    input logic                 clk,
    input logic                 rst,
    room_thermal_model_if.slave bus
);

    localparam int MAXHC  = (HEAT_DIV > COOL_DIV) ? HEAT_DIV : COOL_DIV;
    localparam int MAXDIV = (MAXHC > DRIFT_DIV) ? MAXHC : DRIFT_DIV;
    localparam int CW     = (MAXDIV > 2) ? $clog2(MAXDIV) : 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t HEAT_LAST  = cnt_t'(HEAT_DIV - 1);
    localparam cnt_t COOL_LAST  = cnt_t'(COOL_DIV - 1);
    localparam cnt_t DRIFT_LAST = cnt_t'(DRIFT_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAT,
        S_COOL,
        S_FAULT
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    cnt_t       r_cnt;
    cnt_t       w_next_cnt;
    cnt_t       w_last;
    logic [4:0] r_temp;
    logic [4:0] w_next_temp;
    logic [4:0] w_target;
    logic       r_step;
    logic       w_next_step;
    logic       r_fault;
    logic       w_heat;
    logic       w_cool;

`ifdef THERMAL_LAG_EN
    logic [3:0] r_heat_sr;
    logic [3:0] r_cool_sr;

    // Element warm-up: commands reach the decoder four edges late.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_heat_sr <= '0;
            r_cool_sr <= '0;
        end else begin
            r_heat_sr <= {r_heat_sr[2:0], bus.heating};
            r_cool_sr <= {r_cool_sr[2:0], bus.cooling};
        end
    end

    assign w_heat = r_heat_sr[3];
    assign w_cool = r_cool_sr[3];
`else
    assign w_heat = bus.heating;
    assign w_cool = bus.cooling;
`endif

    // Mode decode plus per-mode divider limit and saturated step target.
    always_comb begin
        w_next_state = S_IDLE;
        w_last       = DRIFT_LAST;
        w_target     = r_temp;
        unique case (1'b1)
            (w_heat && w_cool): w_next_state = S_FAULT;
            (w_heat && !w_cool): w_next_state = S_HEAT;
            (!w_heat && w_cool): w_next_state = S_COOL;
            default: w_next_state = S_IDLE;
        endcase
        case (r_state)
            S_HEAT: begin
                w_last = HEAT_LAST;
                if (r_temp != 5'd31) begin
                    w_target = r_temp + 5'd1;
                end
            end
            S_COOL: begin
                w_last = COOL_LAST;
                if (r_temp != 5'd0) begin
                    w_target = r_temp - 5'd1;
                end
            end
            S_IDLE: begin
                w_last = DRIFT_LAST;
                if (bus.ambient > r_temp) begin
                    w_target = r_temp + 5'd1;
                end else if (bus.ambient < r_temp) begin
                    w_target = r_temp - 5'd1;
                end
            end
            default: begin
                w_last   = DRIFT_LAST;
                w_target = r_temp;
            end
        endcase
    end

    // Divider and temperature update; a mode change restarts the divider.
    always_comb begin
        w_next_cnt  = r_cnt;
        w_next_temp = r_temp;
        w_next_step = 1'b0;
        if (w_next_state != r_state) begin
            w_next_cnt = '0;
        end else if (r_state == S_FAULT) begin
            w_next_cnt = '0;
        end else if (r_cnt == w_last) begin
            w_next_cnt  = '0;
            w_next_temp = w_target;
            w_next_step = (w_target != r_temp);
        end else begin
            w_next_cnt = r_cnt + 1'b1;
        end
    end

    // State, divider and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_temp  <= 5'(RESET_TEMP);
            r_step  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_temp  <= w_next_temp;
            r_step  <= w_next_step;
            r_fault <= (w_next_state == S_FAULT);
        end
    end

    assign bus.temperature = r_temp;
    assign bus.temp_step   = r_step;
    assign bus.fault       = r_fault;

endmodule

// File: tb/tb_room_thermal_model.sv
// Bench for room_thermal_model: per-cycle reference model plus
// literal checkpoints; honours THERMAL_LAG_EN when defined.
module tb_room_thermal_model;

    localparam int HEAT_DIV   = 8;
    localparam int COOL_DIV   = 8;
    localparam int DRIFT_DIV  = 32;
    localparam int RESET_TEMP = 18;
`ifdef THERMAL_LAG_EN
    localparam int LAG = 4;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    room_thermal_model_if bus ();

    room_thermal_model #(
        .HEAT_DIV  (HEAT_DIV),
        .COOL_DIV  (COOL_DIV),
        .DRIFT_DIV (DRIFT_DIV),
        .RESET_TEMP(RESET_TEMP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference: mode 0 idle, 1 heat, 2 cool, 3 fault; age = edges
    // spent in the current mode; a step lands every DIV edges of age.
    typedef struct {
        int         mode;
        int         age;
        int         temp;
        int         step;
        logic [3:0] hh;
        logic [3:0] hc;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.mode = 0;
        r.age  = 0;
        r.temp = RESET_TEMP;
        r.step = 0;
        r.hh   = '0;
        r.hc   = '0;
        return r;
    endfunction

    function automatic model_t model_next(model_t cur, logic h, logic c,
                                          int amb);
        model_t n;
        logic   dh;
        logic   dc;
        int     nm;
        int     div;
        int     tgt;
        n = cur;
        n.step = 0;
        if (LAG > 0) begin
            dh = cur.hh[3];
            dc = cur.hc[3];
        end else begin
            dh = h;
            dc = c;
        end
        n.hh = {cur.hh[2:0], h};
        n.hc = {cur.hc[2:0], c};
        if (dh && dc) nm = 3;
        else if (dh) nm = 1;
        else if (dc) nm = 2;
        else nm = 0;
        if (nm != cur.mode) begin
            n.mode = nm;
            n.age  = 0;
        end else begin
            n.age = cur.age + 1;
            if (nm != 3) begin
                div = (nm == 1) ? HEAT_DIV : (nm == 2) ? COOL_DIV : DRIFT_DIV;
                if (n.age % div == 0) begin
                    tgt = cur.temp;
                    if (nm == 1 && cur.temp < 31) tgt = cur.temp + 1;
                    if (nm == 2 && cur.temp > 0) tgt = cur.temp - 1;
                    if (nm == 0 && amb > cur.temp) tgt = cur.temp + 1;
                    if (nm == 0 && amb < cur.temp) tgt = cur.temp - 1;
                    if (tgt != cur.temp) begin
                        n.temp = tgt;
                        n.step = 1;
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d",
                     name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else m <= model_next(m, bus.heating, bus.cooling, int'(bus.ambient));
    end

    // Every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("temperature", int'(bus.temperature), m.temp);
        chk("temp_step", int'(bus.temp_step), m.step);
        chk("fault", int'(bus.fault), (m.mode == 3) ? 1 : 0);
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        bus.heating = 1'b0;
        bus.cooling = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int sel;
        int len;
        bus.heating = 1'b0;
        bus.cooling = 1'b0;
        bus.ambient = 5'd18;

        // Reset values and quiet idle at ambient.
        wait_n(3);
        chk("lit_reset_temp", int'(bus.temperature), 18);
        chk("lit_reset_step", int'(bus.temp_step), 0);
        chk("lit_reset_fault", int'(bus.fault), 0);
        #2 rst = 1'b1;
        wait_n(200);
        chk("lit_idle_hold", int'(bus.temperature), 18);

        // Drift toward ambient 21, then retarget to 15 mid-count.
        bus.ambient = 5'd21;
        do_reset();
        wait_n(31);
        chk("lit_drift_pre", int'(bus.temperature), 18);
        wait_n(1);
        chk("lit_drift_1", int'(bus.temperature), 19);
        wait_n(32);
        chk("lit_drift_2", int'(bus.temperature), 20);
        wait_n(32);
        chk("lit_drift_3", int'(bus.temperature), 21);
        wait_n(40);
        chk("lit_drift_hold", int'(bus.temperature), 21);
        bus.ambient = 5'd15;
        wait_n(23);
        chk("lit_amb_pre", int'(bus.temperature), 21);
        wait_n(1);
        chk("lit_amb_down", int'(bus.temperature), 20);

        // Heating ramp, then saturation at 31.
        bus.ambient = 5'd18;
        do_reset();
        bus.heating = 1'b1;
        wait_n(8 + LAG);
        chk("lit_heat_pre", int'(bus.temperature), 18);
        wait_n(1);
        chk("lit_heat_1", int'(bus.temperature), 19);
        chk("lit_heat_pulse", int'(bus.temp_step), 1);
        wait_n(1);
        chk("lit_heat_pulse_end", int'(bus.temp_step), 0);
        wait_n(7);
        chk("lit_heat_2", int'(bus.temperature), 20);
        wait_n(120);
        chk("lit_heat_sat", int'(bus.temperature), 31);

        // Cooling down to the floor.
        bus.heating = 1'b0;
        bus.cooling = 1'b1;
        wait_n(300);
        chk("lit_cool_sat", int'(bus.temperature), 0);
        chk("lit_cool_nopulse", int'(bus.temp_step), 0);

        // Fault during a heat ramp at div_cnt 5, then release.
        do_reset();
        bus.heating = 1'b1;
        wait_n(6);
        bus.cooling = 1'b1;
        wait_n(LAG + 1);
        chk("lit_fault_on", int'(bus.fault), 1);
        chk("lit_fault_frozen", int'(bus.temperature), 18);
        wait_n(9 - LAG);
        bus.cooling = 1'b0;
        wait_n(8 + LAG);
        chk("lit_fault_off", int'(bus.fault), 0);
        chk("lit_reentry_pre", int'(bus.temperature), 18);
        wait_n(1);
        chk("lit_reentry_step", int'(bus.temperature), 19);

        // Randomised command segments, glitches and resets.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 19) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) bus.ambient = 5'($urandom_range(0, 31));
            sel = $urandom_range(0, 9);
            len = ($urandom_range(0, 4) == 0) ? 1 : $urandom_range(1, 60);
            bus.heating = (sel <= 3) || (sel == 9);
            bus.cooling = (sel >= 4 && sel <= 6) || (sel == 9);
            wait_n(len);
        end
        bus.heating = 1'b0;
        bus.cooling = 1'b0;
        wait_n(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
